// File: rtl/data_memory_mmio_pkg.sv
// Shared types and address decode for the load/store data memory.
// Contents:
//   state_t        sweep/run controller states
//   addr_class_t   classification of a request byte address
//   OUT_OFS/IN_OFS byte offsets of the two MMIO words from the window base
//   decode_addr()  maps a byte address to addr_class_t
package data_memory_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    RAM,
    MMIO_OUT,
    MMIO_IN,
    BAD
  } addr_class_t;

  localparam logic [63:0] OUT_OFS = 64'd0;
  localparam logic [63:0] IN_OFS  = 64'd4;

  // Decode happens on word indices, so byte-offset bits below the word are
  // ignored for both RAM and the MMIO window. RAM takes priority in case a
  // large DEPTH ever overlaps the window.
  function automatic addr_class_t decode_addr(input logic [63:0] addr,
                                              input logic [63:0] base,
                                              input int unsigned depth,
                                              input int unsigned lsb);
    logic [63:0] widx;
    widx = addr >> lsb;
    if (widx < 64'(depth))                    return RAM;
    else if (widx == ((base + OUT_OFS) >> lsb)) return MMIO_OUT;
    else if (widx == ((base + IN_OFS) >> lsb))  return MMIO_IN;
    else                                        return BAD;
  endfunction

endpackage

// File: rtl/data_memory_mmio_if.sv
// Request/response bus between the load/store stage and the data memory.
// Signals:
//   req_valid/req_ready  request handshake (accept = valid & ready)
//   req_write            1 = store, 0 = load
//   req_addr             byte address
//   req_wdata/req_be     store data and byte-lane enables
//   rsp_valid            one-cycle ack, one cycle after acceptance
//   rsp_rdata/rsp_err    load data and address-range error, 0 when rsp_valid=0
// Modports: master (core side), slave (memory side).
interface data_memory_mmio_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_mmio_sync_2ff.sv
// Two-flop synchroniser for asynchronous multi-bit board inputs. Each bit is
// synchronised independently; the bus is not guaranteed coherent across bits.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset, clears both stages
//   d      asynchronous input
//   q      synchronised output (2 cycles latency)
module sync_2ff #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/data_memory_mmio.sv
// Single-port data memory for the core's load/store stage with byte enables,
// a registered one-cycle response, an address-range error flag, a
// clear-after-reset sweep and a two-word MMIO window (LED out, switch in).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          data_memory_mmio_if.slave request/response bus
//   periph_in    asynchronous board inputs (synchronised internally)
//   periph_out   registered board outputs
//   init_busy    RAM clear sweep in progress
//
// state | meaning
// CLEAR | zero RAM[sweep_idx] each cycle, requests blocked
// RUN   | normal operation, req_ready=1
module data_memory_mmio
  import data_memory_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 1024,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       PERIPH_W    = 8,
  parameter logic [ADDR_W-1:0] PERIPH_BASE = ADDR_W'(32'h0000_F000)
) (
  input  logic                clk,
  input  logic                rst,
  data_memory_mmio_if.slave   bus,
  input  logic [PERIPH_W-1:0] periph_in,
  output logic [PERIPH_W-1:0] periph_out,
  output logic                init_busy
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(NB);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NB-1:0][7:0] mem [DEPTH];

  state_t              state;
  logic [IDX_W-1:0]    sweep_idx;
  logic                ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic [PERIPH_W-1:0] periph_sync;

  addr_class_t         cls;
  logic [IDX_W-1:0]    ram_idx;
  logic                accept;
  logic [DATA_W-1:0]   rd_data;

  assign cls     = decode_addr(64'(bus.req_addr), 64'(PERIPH_BASE), DEPTH, LSB);
  assign ram_idx = bus.req_addr[LSB +: IDX_W];
  assign accept  = bus.req_valid & ready_q;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  sync_2ff #(.W(PERIPH_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (periph_in),
    .q   (periph_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      sweep_idx <= '0;
      init_busy <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (sweep_idx == IDX_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_busy <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + IDX_W'(1);
          end
        end
        RUN: begin
          init_busy <= 1'b0;
          ready_q   <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Sweep and store share one write port; they are exclusive because
  // req_ready is low for the whole sweep. Gated by rst so a request seen in
  // the reset cycle cannot leave a side effect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[sweep_idx] <= '0;
      end else if (accept && bus.req_write && cls == RAM) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.req_be[i]) mem[ram_idx][i] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read mux sees the array before this edge's write, so a load accepted on
  // the cycle after a store to the same word returns the stored data.
  always_comb begin
    rd_data = '0;
    case (cls)
      RAM:      rd_data = mem[ram_idx];
      MMIO_OUT: rd_data = DATA_W'(periph_out);
      MMIO_IN:  rd_data = DATA_W'(periph_sync);
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      periph_out  <= '0;
    end else begin
      rsp_valid_q <= accept;
      rsp_rdata_q <= (accept && !bus.req_write) ? rd_data : '0;
      rsp_err_q   <= accept && (cls == BAD);
      if (accept && bus.req_write && cls == MMIO_OUT && bus.req_be[0])
        periph_out <= bus.req_wdata[PERIPH_W-1:0];
    end
  end

endmodule
